// File: rtl/mem_stage_responder.sv
// mem_stage_responder: MEM pipeline stage with a wait-stated word RAM and the
// MEM/WB pipeline register.
//
// A memory operation (load and/or store) is sampled in IDLE. It stalls the
// upstream pipeline for WAIT_CYCLES cycles and writes MEM/WB on the posedge
// that ends the DONE cycle. Non-memory operations pass straight into MEM/WB
// with one cycle of latency and no stall.
//
// Wait counter: it holds the number of WAIT cycles still to run, counting the
// current one. IDLE spends the first stall cycle and loads WAIT_CYCLES-1. The
// RAM access happens on the posedge where the counter runs out. When
// WAIT_CYCLES=1 the counter starts at zero, so the access happens on the IDLE
// posedge and the FSM goes straight to DONE.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap memory ops whose
// address is not word aligned. A trapped op skips the RAM write, sets
// MisalignW and clears RegWriteW. When the macro is not defined, the low
// address bits are ignored and MisalignW is always 0.
module mem_stage_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  WA3M,
   input  logic        RegWriteM,
   input  logic        MemToRegM,
   input  logic        MemWriteM,
   output logic        StallM,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [3:0]  WA3W,
   output logic        RegWriteW,
   output logic        MemToRegW,
   output logic        MisalignW
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   // operation captured in IDLE and held while the access is in flight
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wa3_q, wa3_d;
   logic        regwrite_q, regwrite_d;
   logic        memtoreg_q, memtoreg_d;
   logic        memwrite_q, memwrite_d;
   logic [31:0] rdata_q, rdata_d;
   logic        mis_q, mis_d;

   // MEM/WB pipeline register
   logic [31:0] read_data_w_q, read_data_w_d;
   logic [31:0] alu_out_w_q, alu_out_w_d;
   logic [3:0]  wa3_w_q, wa3_w_d;
   logic        regwrite_w_q, regwrite_w_d;
   logic        memtoreg_w_q, memtoreg_w_d;
   logic        misalign_w_q, misalign_w_d;

   // access path
   logic [31:0] ram_q [0:DEPTH-1];
   logic [31:0] acc_addr_s;
   logic [31:0] acc_wdata_s;
   logic        acc_memwrite_s;
   logic [AW-1:0] idx_s;
   logic [31:0] rd_word_s;
   logic        mis_s;
   logic        mem_op_s;
   logic        stall_s;
   logic        access_s;
   logic        ram_we_s;
   logic        unused_s;

   assign mem_op_s  = MemToRegM | MemWriteM;
   assign idx_s     = acc_addr_s[AW+1:2];
   assign rd_word_s = ram_q[idx_s];
   assign ram_we_s  = access_s & acc_memwrite_s & ~mis_s & ~reset;
   assign unused_s  = ^{acc_addr_s[31:AW+2], acc_addr_s[1:0]};

   // access operands: live inputs in IDLE, captured copy once the op is in flight
   always_comb begin
      acc_addr_s     = addr_q;
      acc_wdata_s    = wdata_q;
      acc_memwrite_s = memwrite_q;
      if (state_q == IDLE) begin
         acc_addr_s     = ALUResultM;
         acc_wdata_s    = WriteDataM;
         acc_memwrite_s = MemWriteM;
      end else begin
         acc_addr_s     = addr_q;
         acc_wdata_s    = wdata_q;
         acc_memwrite_s = memwrite_q;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   // trap any access whose byte offset within the word is non-zero
   always_comb begin
      mis_s = |acc_addr_s[1:0];
   end
`else
   // low address bits are ignored; no trap
   always_comb begin
      mis_s = 1'b0;
   end
`endif

   // next-state, stall and MEM/WB next values
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wa3_d         = wa3_q;
      regwrite_d    = regwrite_q;
      memtoreg_d    = memtoreg_q;
      memwrite_d    = memwrite_q;
      rdata_d       = rdata_q;
      mis_d         = mis_q;
      read_data_w_d = read_data_w_q;
      alu_out_w_d   = alu_out_w_q;
      wa3_w_d       = wa3_w_q;
      regwrite_w_d  = regwrite_w_q;
      memtoreg_w_d  = memtoreg_w_q;
      misalign_w_d  = misalign_w_q;
      stall_s       = 1'b0;
      access_s      = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_op_s) begin
               addr_d     = ALUResultM;
               wdata_d    = WriteDataM;
               wa3_d      = WA3M;
               regwrite_d = RegWriteM;
               memtoreg_d = MemToRegM;
               memwrite_d = MemWriteM;
               if (WAIT_CYCLES == 0) begin
                  // zero-wait memory: access and MEM/WB load on this posedge
                  access_s      = 1'b1;
                  read_data_w_d = rd_word_s;
                  alu_out_w_d   = ALUResultM;
                  wa3_w_d       = WA3M;
                  regwrite_w_d  = RegWriteM & ~mis_s;
                  memtoreg_w_d  = MemToRegM;
                  misalign_w_d  = mis_s;
               end else begin
                  stall_s      = 1'b1;
                  regwrite_w_d = 1'b0;
                  memtoreg_w_d = 1'b0;
                  misalign_w_d = 1'b0;
                  if (WAIT_CYCLES == 1) begin
                     access_s = 1'b1;
                     rdata_d  = rd_word_s;
                     mis_d    = mis_s;
                     cnt_d    = 4'd0;
                     state_d  = DONE;
                  end else begin
                     cnt_d   = WAIT_LOAD;
                     state_d = WAIT;
                  end
               end
            end else begin
               // pass-through op: straight into MEM/WB
               alu_out_w_d  = ALUResultM;
               wa3_w_d      = WA3M;
               regwrite_w_d = RegWriteM;
               memtoreg_w_d = MemToRegM;
               misalign_w_d = 1'b0;
            end
         end
         WAIT: begin
            stall_s      = 1'b1;
            regwrite_w_d = 1'b0;
            memtoreg_w_d = 1'b0;
            misalign_w_d = 1'b0;
            if (cnt_q <= 4'd1) begin
               access_s = 1'b1;
               rdata_d  = rd_word_s;
               mis_d    = mis_s;
               cnt_d    = 4'd0;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            read_data_w_d = rdata_q;
            alu_out_w_d   = addr_q;
            wa3_w_d       = wa3_q;
            regwrite_w_d  = regwrite_q & ~mis_q;
            memtoreg_w_d  = memtoreg_q;
            misalign_w_d  = mis_q;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // state, captured op and MEM/WB register; reset clears everything but the RAM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         wa3_q         <= 4'd0;
         regwrite_q    <= 1'b0;
         memtoreg_q    <= 1'b0;
         memwrite_q    <= 1'b0;
         rdata_q       <= 32'd0;
         mis_q         <= 1'b0;
         read_data_w_q <= 32'd0;
         alu_out_w_q   <= 32'd0;
         wa3_w_q       <= 4'd0;
         regwrite_w_q  <= 1'b0;
         memtoreg_w_q  <= 1'b0;
         misalign_w_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wa3_q         <= wa3_d;
         regwrite_q    <= regwrite_d;
         memtoreg_q    <= memtoreg_d;
         memwrite_q    <= memwrite_d;
         rdata_q       <= rdata_d;
         mis_q         <= mis_d;
         read_data_w_q <= read_data_w_d;
         alu_out_w_q   <= alu_out_w_d;
         wa3_w_q       <= wa3_w_d;
         regwrite_w_q  <= regwrite_w_d;
         memtoreg_w_q  <= memtoreg_w_d;
         misalign_w_q  <= misalign_w_d;
      end
   end

   // data RAM: one write on the access posedge; never touched by reset
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_q[idx_s] <= acc_wdata_s;
      end
   end

   assign StallM    = stall_s;
   assign ReadDataW = read_data_w_q;
   assign ALUOutW   = alu_out_w_q;
   assign WA3W      = wa3_w_q;
   assign RegWriteW = regwrite_w_q;
   assign MemToRegW = memtoreg_w_q;
   assign MisalignW = misalign_w_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed bench for mem_stage_responder: instance a (WAIT_CYCLES=2) and instance b (WAIT_CYCLES=0).
module tb_mem_stage_responder;

   logic clk = 1'b0;
   logic reset;

   logic [31:0] a_alu, a_wd, a_rd, a_ao;
   logic [3:0]  a_wa3, a_wa3w;
   logic        a_rw, a_m2r, a_mw, a_stall, a_rww, a_m2rw, a_mis;

   logic [31:0] b_alu, b_wd, b_rd, b_ao;
   logic [3:0]  b_wa3, b_wa3w;
   logic        b_rw, b_m2r, b_mw, b_stall, b_rww, b_m2rw, b_mis;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset),
      .ALUResultM(a_alu), .WriteDataM(a_wd), .WA3M(a_wa3),
      .RegWriteM(a_rw), .MemToRegM(a_m2r), .MemWriteM(a_mw),
      .StallM(a_stall), .ReadDataW(a_rd), .ALUOutW(a_ao), .WA3W(a_wa3w),
      .RegWriteW(a_rww), .MemToRegW(a_m2rw), .MisalignW(a_mis)
   );

   mem_stage_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset),
      .ALUResultM(b_alu), .WriteDataM(b_wd), .WA3M(b_wa3),
      .RegWriteM(b_rw), .MemToRegM(b_m2r), .MemWriteM(b_mw),
      .StallM(b_stall), .ReadDataW(b_rd), .ALUOutW(b_ao), .WA3W(b_wa3w),
      .RegWriteW(b_rww), .MemToRegW(b_m2rw), .MisalignW(b_mis)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_a(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wa3,
                          input logic rw, input logic m2r, input logic mw);
      a_alu = addr; a_wd = wd; a_wa3 = wa3; a_rw = rw; a_m2r = m2r; a_mw = mw;
   endtask

   task automatic drive_b(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wa3,
                          input logic rw, input logic m2r, input logic mw);
      b_alu = addr; b_wd = wd; b_wa3 = wa3; b_rw = rw; b_m2r = m2r; b_mw = mw;
   endtask

   // Issue one op on instance a, hold it through the stall, count stall cycles,
   // check a bubble after every stalled posedge, and return #1 after the MEM/WB load.
   task automatic op_a(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wa3, input logic rw, input logic m2r, input logic mw,
                       input int exp_stalls, input bit perturb);
      int stalls = 0;
      bit done = 1'b0;
      drive_a(addr, wd, wa3, rw, m2r, mw);
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (a_stall === 1'b1) begin
            stalls++;
            @(posedge clk); #1;
            chk($sformatf("%s_bubble_rw", tag), {31'd0, a_rww}, 32'd0);
            chk($sformatf("%s_bubble_m2r", tag), {31'd0, a_m2rw}, 32'd0);
            if (perturb) begin
               drive_a(addr ^ 32'h0000_0004, ~wd, ~wa3, ~rw, m2r, mw);
            end
         end else begin
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      chk($sformatf("%s_completed", tag), {31'd0, done}, 32'd1);
      chk($sformatf("%s_stalls", tag), stalls, exp_stalls);
      drive_a(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      drive_a(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      drive_b(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;

      // reset state
      chk("rst_rd",    a_rd, 32'd0);
      chk("rst_ao",    a_ao, 32'd0);
      chk("rst_wa3",   {28'd0, a_wa3w}, 32'd0);
      chk("rst_rw",    {31'd0, a_rww}, 32'd0);
      chk("rst_m2r",   {31'd0, a_m2rw}, 32'd0);
      chk("rst_mis",   {31'd0, a_mis}, 32'd0);
      chk("rst_stall", {31'd0, a_stall}, 32'd0);

      // non-memory pass-through: one cycle, no stall
      op_a("pass", 32'h0000_1234, 32'd0, 4'd5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk("pass_ao",  a_ao, 32'h0000_1234);
      chk("pass_wa3", {28'd0, a_wa3w}, 32'd5);
      chk("pass_rw",  {31'd0, a_rww}, 32'd1);
      chk("pass_m2r", {31'd0, a_m2rw}, 32'd0);

      // store 0xDEADBEEF to 0x10 (word 4)
      op_a("store", 32'h0000_0010, 32'hDEAD_BEEF, 4'd3, 1'b0, 1'b0, 1'b1, 2, 1'b0);
      chk("store_rw",  {31'd0, a_rww}, 32'd0);
      chk("store_m2r", {31'd0, a_m2rw}, 32'd0);
      chk("store_ao",  a_ao, 32'h0000_0010);
      chk("store_wa3", {28'd0, a_wa3w}, 32'd3);

      // load back from 0x10
      op_a("load", 32'h0000_0010, 32'd0, 4'd7, 1'b1, 1'b1, 1'b0, 2, 1'b0);
      chk("load_rd",  a_rd, 32'hDEAD_BEEF);
      chk("load_m2r", {31'd0, a_m2rw}, 32'd1);
      chk("load_wa3", {28'd0, a_wa3w}, 32'd7);
      chk("load_rw",  {31'd0, a_rww}, 32'd1);
      chk("load_ao",  a_ao, 32'h0000_0010);
      chk("load_mis", {31'd0, a_mis}, 32'd0);

      // inputs changing during WAIT must be ignored
      op_a("pstore", 32'h0000_0020, 32'h1111_1111, 4'd2, 1'b0, 1'b0, 1'b1, 2, 1'b1);
      chk("pstore_ao",  a_ao, 32'h0000_0020);
      chk("pstore_wa3", {28'd0, a_wa3w}, 32'd2);
      op_a("pload", 32'h0000_0020, 32'd0, 4'd6, 1'b1, 1'b1, 1'b0, 2, 1'b1);
      chk("pload_rd",  a_rd, 32'h1111_1111);
      chk("pload_wa3", {28'd0, a_wa3w}, 32'd6);
      chk("pload_rw",  {31'd0, a_rww}, 32'd1);

      // load+store in one op returns the pre-write word
      op_a("rmw", 32'h0000_0010, 32'hCAFE_F00D, 4'd8, 1'b1, 1'b1, 1'b1, 2, 1'b0);
      chk("rmw_rd",  a_rd, 32'hDEAD_BEEF);
      chk("rmw_m2r", {31'd0, a_m2rw}, 32'd1);
      op_a("rmw_chk", 32'h0000_0010, 32'd0, 4'd8, 1'b1, 1'b1, 1'b0, 2, 1'b0);
      chk("rmw_chk_rd", a_rd, 32'hCAFE_F00D);

      // misaligned store to 0x13
      op_a("mis", 32'h0000_0013, 32'hA5A5_A5A5, 4'd4, 1'b1, 1'b0, 1'b1, 2, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_flag", {31'd0, a_mis}, 32'd1);
      chk("mis_rw",   {31'd0, a_rww}, 32'd0);
      op_a("mis_chk", 32'h0000_0010, 32'd0, 4'd1, 1'b1, 1'b1, 1'b0, 2, 1'b0);
      chk("mis_chk_rd",  a_rd, 32'hCAFE_F00D);
      chk("mis_chk_mis", {31'd0, a_mis}, 32'd0);
`else
      chk("mis_flag", {31'd0, a_mis}, 32'd0);
      chk("mis_rw",   {31'd0, a_rww}, 32'd1);
      op_a("mis_chk", 32'h0000_0010, 32'd0, 4'd1, 1'b1, 1'b1, 1'b0, 2, 1'b0);
      chk("mis_chk_rd", a_rd, 32'hA5A5_A5A5);
`endif

      // reset during WAIT aborts a store of 0x55 to 0x20
      drive_a(32'h0000_0020, 32'h0000_0055, 4'd9, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("abort_stall", {31'd0, a_stall}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      drive_a(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_rd",    a_rd, 32'd0);
      chk("abort_ao",    a_ao, 32'd0);
      chk("abort_wa3",   {28'd0, a_wa3w}, 32'd0);
      chk("abort_rw",    {31'd0, a_rww}, 32'd0);
      chk("abort_m2r",   {31'd0, a_m2rw}, 32'd0);
      chk("abort_stall0", {31'd0, a_stall}, 32'd0);
      op_a("abort_chk", 32'h0000_0020, 32'd0, 4'd2, 1'b1, 1'b1, 1'b0, 2, 1'b0);
      chk("abort_chk_rd", a_rd, 32'h1111_1111);

      // zero-wait instance: store to 0x10, then load alias 0x110 (word 4)
      drive_b(32'h0000_0010, 32'h0000_0077, 4'd1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("b_store_stall", {31'd0, b_stall}, 32'd0);
      @(posedge clk); #1;
      chk("b_store_ao", b_ao, 32'h0000_0010);
      chk("b_store_rw", {31'd0, b_rww}, 32'd0);
      drive_b(32'h0000_0110, 32'd0, 4'd2, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("b_load_stall", {31'd0, b_stall}, 32'd0);
      @(posedge clk); #1;
      chk("b_load_rd",  b_rd, 32'h0000_0077);
      chk("b_load_wa3", {28'd0, b_wa3w}, 32'd2);
      chk("b_load_rw",  {31'd0, b_rww}, 32'd1);
      chk("b_load_m2r", {31'd0, b_m2rw}, 32'd1);
      chk("b_load_ao",  b_ao, 32'h0000_0110);
      drive_b(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_responder.md
MEM_STAGE_RESPONDER -- requirements
Module: mem_stage_responder

Interface
REQ-001 Parameter DEPTH, default 64, data-memory depth in 32-bit words (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states per memory access (0..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ALUResultM  input  32  byte address for memory ops, or ALU result for non-memory ops.
REQ-006 WriteDataM  input  32  store data.
REQ-007 WA3M  input  4  destination register.
REQ-008 RegWriteM, MemToRegM, MemWriteM  input  1 each  control bits from the EXE/MEM pipeline register.
REQ-009 StallM  output  1  combinational; high holds EXE/MEM and all upstream stages.
REQ-010 ReadDataW, ALUOutW  output  32 each  MEM/WB register: load data and pass-through ALU result.
REQ-011 WA3W  output  4  MEM/WB destination register.
REQ-012 RegWriteW, MemToRegW  output  1 each  MEM/WB control bits.
REQ-013 MisalignW  output  1  MEM/WB misalignment flag (REQ-033).

Function
REQ-014 Word index SHALL be ALUResultM[log2(DEPTH)+1:2]; higher address bits ignored (addresses wrap modulo DEPTH*4).
REQ-015 A memory op SHALL be any cycle with MemToRegM=1 or MemWriteM=1; all other cycles are pass-through.
REQ-016 FSM states SHALL be IDLE, WAIT, DONE; reset state IDLE.
REQ-017 IDLE, memory op, WAIT_CYCLES>0: StallM=1 same cycle, wait counter loads WAIT_CYCLES-1, next state WAIT.
REQ-018 WAIT: StallM=1; counter decrements each cycle; at counter=0, RAM access happens on that posedge, next state DONE.
REQ-019 DONE: StallM=0; MEM/WB register loads on this posedge; next state IDLE.
REQ-020 Memory op with WAIT_CYCLES=0 SHALL complete in IDLE with StallM=0 and no stall cycles.
REQ-021 Op latency SHALL be WAIT_CYCLES+1 cycles from op entry to MEM/WB load; pass-through latency exactly 1 cycle.
REQ-022 Store: RAM[index] <= WriteDataM at the access posedge only; exactly one write per store.
REQ-023 Load: ReadDataW SHALL equal RAM[index] as of before the access posedge.
REQ-024 MemWriteM=1 with MemToRegM=1: write performed; ReadDataW returns pre-write word.
REQ-025 While StallM=1 the MEM/WB register SHALL load a bubble: RegWriteW=0, MemToRegW=0, data outputs hold.
REQ-026 Inputs SHALL be sampled only in IDLE and held by upstream during stall; inputs changing during WAIT are ignored.
REQ-027 Back-to-back memory ops: DONE returns to IDLE; next op starts its own WAIT sequence with no lost or duplicated access.
REQ-028 When StallM=0 in IDLE, MEM/WB SHALL load ALUOutW<=ALUResultM, WA3W<=WA3M, RegWriteW<=RegWriteM, MemToRegW<=MemToRegM.

Reset
REQ-029 Reset SHALL force state IDLE, counter 0, all MEM/WB outputs 0, StallM 0 on the next posedge.
REQ-030 Reset during WAIT SHALL abort the op: no RAM write, no MEM/WB load.
REQ-031 RAM contents SHALL NOT be affected by reset.
REQ-032 Reset has priority over all other events in the same cycle.

Configuration
REQ-033 With MEM_MISALIGN_TRAP_EN defined: memory op with ALUResultM[1:0]!=0 SHALL skip the RAM write, set MisalignW=1 and force RegWriteW=0 at MEM/WB load; timing unchanged.
REQ-034 Without MEM_MISALIGN_TRAP_EN: ALUResultM[1:0] ignored, MisalignW tied 0.

Verification
REQ-035 WAIT_CYCLES=2, store 0xDEADBEEF to 0x10 -> StallM high 2 cycles; RAM[4]=0xDEADBEEF; RegWriteW=0 at completion.
REQ-036 Load 0x10 after REQ-035 -> StallM high 2 cycles; then ReadDataW=0xDEADBEEF, MemToRegW=1, WA3W=WA3M.
REQ-037 Non-memory op ALUResultM=0x1234, WA3M=5, RegWriteM=1 -> next cycle ALUOutW=0x1234, WA3W=5, RegWriteW=1, no stall.
REQ-038 Store 0x55 to 0x20, reset asserted in WAIT -> RAM[8] unchanged, outputs 0, state IDLE after one cycle.
REQ-039 Address 0x110 with DEPTH=64 -> aliases to word 4; WAIT_CYCLES=0 load completes with StallM never high.
REQ-040 MEM_MISALIGN_TRAP_EN defined, store to 0x13 -> RAM unchanged, MisalignW=1, RegWriteW=0.
